// File: rtl/fetch_sequencer_if.sv
// Fetch/datapath bus between the fetch unit and the fetch sequencer.
// The master modport is the fetch unit plus datapath side. The slave modport
// is the sequencer.
interface fetch_sequencer_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        write_pc;
  logic        is_branch;
  logic        is_jump;
  logic        is_jr;
  logic [15:0] branch_addr;
  logic [25:0] jump_addr;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  alu_op;
  logic        mem_timeout;
  logic        trap;

  modport master (
    output instr, zero, mem_ready,
    input  write_pc, is_branch, is_jump, is_jr, branch_addr, jump_addr,
    input  reg_write, mem_read, mem_write, alu_op, mem_timeout, trap
  );

  modport slave (
    input  instr, zero, mem_ready,
    output write_pc, is_branch, is_jump, is_jr, branch_addr, jump_addr,
    output reg_write, mem_read, mem_write, alu_op, mem_timeout, trap
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM at the far end of the fetch
// interface. It latches the instruction word, decodes it, and drives the PC
// update controls and the datapath enables.
// Optional build macro FETCH_SEQ_TRAP_EN: when defined, an illegal opcode
// parks the FSM in ILLEGAL with a sticky trap flag. When undefined, an illegal
// opcode executes as a one-cycle NOP and trap is tied low.
module fetch_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic              clk,
  input logic              rst_n,
  fetch_sequencer_if.slave bus
);

  localparam logic [2:0] StFetch   = 3'd0;
  localparam logic [2:0] StDecode  = 3'd1;
  localparam logic [2:0] StExec    = 3'd2;
  localparam logic [2:0] StMem     = 3'd3;
  localparam logic [2:0] StWb      = 3'd4;
  localparam logic [2:0] StIllegal = 3'd5;

  localparam logic [2:0] AluAdd  = 3'd0;
  localparam logic [2:0] AluSub  = 3'd1;
  localparam logic [2:0] AluSlt  = 3'd2;
  localparam logic [2:0] AluXor  = 3'd3;
  localparam logic [2:0] AluIdle = 3'd7;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpXori  = 6'h0e;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnSlt = 6'h2a;

  localparam logic [3:0] WaitMax = 4'(MEM_WAIT_MAX);

  logic [2:0]  state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;

  // Decoded instruction class
  logic       dec_legal;
  logic       dec_arith;
  logic       dec_lw;
  logic       dec_sw;
  logic       dec_beq;
  logic       dec_bne;
  logic       dec_j;
  logic       dec_jal;
  logic       dec_jr;
  logic [2:0] dec_alu_op;
  logic       dec_pc_only;

  // Classify the held instruction by opcode, and by funct for R-type
  always_comb begin
    dec_legal  = 1'b1;
    dec_arith  = 1'b0;
    dec_lw     = 1'b0;
    dec_sw     = 1'b0;
    dec_beq    = 1'b0;
    dec_bne    = 1'b0;
    dec_j      = 1'b0;
    dec_jal    = 1'b0;
    dec_jr     = 1'b0;
    dec_alu_op = AluIdle;
    case (ir_q[31:26])
      OpRtype: begin
        case (ir_q[5:0])
          FnAdd: begin
            dec_arith  = 1'b1;
            dec_alu_op = AluAdd;
          end
          FnSub: begin
            dec_arith  = 1'b1;
            dec_alu_op = AluSub;
          end
          FnSlt: begin
            dec_arith  = 1'b1;
            dec_alu_op = AluSlt;
          end
          FnJr:    dec_jr    = 1'b1;
          default: dec_legal = 1'b0;
        endcase
      end
      OpAddi: begin
        dec_arith  = 1'b1;
        dec_alu_op = AluAdd;
      end
      OpXori: begin
        dec_arith  = 1'b1;
        dec_alu_op = AluXor;
      end
      OpLw: begin
        dec_lw     = 1'b1;
        dec_alu_op = AluAdd;
      end
      OpSw: begin
        dec_sw     = 1'b1;
        dec_alu_op = AluAdd;
      end
      OpBeq: begin
        dec_beq    = 1'b1;
        dec_alu_op = AluSub;
      end
      OpBne: begin
        dec_bne    = 1'b1;
        dec_alu_op = AluSub;
      end
      OpJ:     dec_j     = 1'b1;
      OpJal:   dec_jal   = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  // Instructions that finish in EXEC with a PC update
  assign dec_pc_only = dec_beq | dec_bne | dec_j | dec_jal | dec_jr;

  // Next-state, instruction register and memory-wait bookkeeping
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    wait_cnt_d    = 4'd0;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      StFetch: begin
        ir_d    = bus.instr;
        state_d = StDecode;
      end
      StDecode: begin
        state_d = dec_legal ? StExec : StIllegal;
      end
      StExec: begin
        if (dec_pc_only) begin
          state_d = StFetch;
        end else if (dec_lw || dec_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        wait_cnt_d = wait_cnt_q;
        if (bus.mem_ready) begin
          state_d = dec_lw ? StWb : StFetch;
        end else if (wait_cnt_q == WaitMax) begin
          // Saturated: flag the overrun but keep the request up
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      StWb: begin
        state_d = StFetch;
      end
      StIllegal: begin
`ifdef FETCH_SEQ_TRAP_EN
        state_d = StIllegal;
`else
        state_d = StFetch;
`endif
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // State, IR, wait counter and sticky timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StFetch;
      ir_q          <= 32'd0;
      wait_cnt_q    <= 4'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef FETCH_SEQ_TRAP_EN
  logic trap_q, trap_d;

  // Trap latches on the way into ILLEGAL and holds until reset
  always_comb begin
    trap_d = trap_q;
    if (state_q == StDecode && !dec_legal) begin
      trap_d = 1'b1;
    end
  end

  // Sticky trap register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign bus.trap = trap_q;
`else
  assign bus.trap = 1'b0;
`endif

  // Per-state control outputs; all of them depend only on state, IR, zero and mem_ready
  always_comb begin
    bus.write_pc  = 1'b0;
    bus.is_branch = 1'b0;
    bus.is_jump   = 1'b0;
    bus.is_jr     = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.alu_op    = AluIdle;
    case (state_q)
      StExec: begin
        bus.alu_op = dec_alu_op;
        if (dec_pc_only) begin
          bus.write_pc  = 1'b1;
          bus.is_branch = (dec_beq & bus.zero) | (dec_bne & ~bus.zero);
          bus.is_jump   = dec_j | dec_jal;
          bus.is_jr     = dec_jr;
          // jal writes the link register in the same cycle
          bus.reg_write = dec_jal;
        end
      end
      StMem: begin
        bus.alu_op    = dec_alu_op;
        bus.mem_read  = dec_lw;
        bus.mem_write = dec_sw;
        bus.write_pc  = dec_sw & bus.mem_ready;
      end
      StWb: begin
        bus.alu_op    = dec_alu_op;
        bus.reg_write = 1'b1;
        bus.write_pc  = 1'b1;
      end
      StIllegal: begin
`ifdef FETCH_SEQ_TRAP_EN
        bus.write_pc = 1'b0;
`else
        bus.write_pc = 1'b1;
`endif
      end
      default: begin
        bus.write_pc = 1'b0;
      end
    endcase
  end

  // Address fields come straight from IR, so they hold until the next fetch
  assign bus.branch_addr = ir_q[15:0];
  assign bus.jump_addr   = ir_q[25:0];
  assign bus.mem_timeout = mem_timeout_q;

endmodule
